// File: rtl/calc_pkg.sv
//------------------------------------------------------------------------------
// Module   : calc_pkg
// Brief    : Shared key codes, operation encodings and entry-state type for the
//            calculator operand entry path.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package calc_pkg;

    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_MUL = 4'hC;
    localparam logic [3:0] KEY_DIV = 4'hD;
    localparam logic [3:0] KEY_CLR = 4'hE;
    localparam logic [3:0] KEY_EQ  = 4'hF;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_DIV = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;

    typedef enum logic [1:0] {
        S_A    = 2'b00,
        S_B    = 2'b01,
        S_DONE = 2'b10,
        S_ERR  = 2'b11
    } entry_state_t;

    function automatic logic is_digit(input logic [3:0] key);
        return (key <= 4'd9);
    endfunction

    function automatic logic is_operator(input logic [3:0] key);
        return (key >= KEY_ADD) && (key <= KEY_DIV);
    endfunction

    // Keypad order is add/sub/mul/div but the calculator encodes div before mul.
    function automatic logic [2:0] key_to_op(input logic [3:0] key);
        logic [2:0] op;
        case (key)
            KEY_SUB: op = OP_SUB;
            KEY_MUL: op = OP_MUL;
            KEY_DIV: op = OP_DIV;
            default: op = OP_ADD;
        endcase
        return op;
    endfunction

endpackage

`default_nettype wire

// File: rtl/digit_accumulator.sv
//------------------------------------------------------------------------------
// Module   : digit_accumulator
// Brief    : Combinational decimal digit append (value*10+digit) with range and
//            digit-count overflow detection for a 4-bit operand.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module digit_accumulator #(
    parameter int MAX_DIGITS = 2,
    parameter int CNT_W      = 2
) (
    input  logic [3:0]       cur_value,
    input  logic [CNT_W-1:0] cur_count,
    input  logic [3:0]       digit,
    output logic [3:0]       next_value,
    output logic [CNT_W-1:0] next_count,
    output logic             overflow
);

    logic [7:0] w_sum;

    // Eight bits hold the worst case 15*10+9 so the range compare sees the true value.
    always_comb begin
        w_sum      = ({4'd0, cur_value} * 8'd10) + {4'd0, digit};
        next_value = w_sum[3:0];
        next_count = cur_count + CNT_W'(1);
        overflow   = (cur_count >= CNT_W'(MAX_DIGITS)) || (w_sum > 8'd15);
    end

endmodule

`default_nettype wire

// File: rtl/operand_entry_fsm.sv
//------------------------------------------------------------------------------
// Module   : operand_entry_fsm
// Brief    : Keypad-driven entry of two decimal operands and an operator,
//            presented as the calculator switch word and operation code.
//            Optional key holdoff masking enabled by defining KEY_HOLDOFF_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module operand_entry_fsm
    import calc_pkg::*;
#(
    parameter int MAX_DIGITS     = 2,
    parameter int HOLDOFF_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_value,
    output logic [7:0] sw_word,
    output logic [2:0] op_sel,
    output logic       calc_valid,
    output logic       err,
    output logic [1:0] entry_state
);

    localparam int c_cnt_w = $clog2(MAX_DIGITS + 1);

    if (MAX_DIGITS < 1) begin : g_bad_max_digits
        $error("MAX_DIGITS must be at least 1");
    end
    if (HOLDOFF_CYCLES < 1) begin : g_bad_holdoff
        $error("HOLDOFF_CYCLES must be at least 1");
    end

    entry_state_t         r_state, w_state_n;
    logic [3:0]           r_a, w_a_n, r_b, w_b_n;
    logic [c_cnt_w-1:0]   r_count_a, w_count_a_n, r_count_b, w_count_b_n;
    logic [2:0]           r_op, w_op_n;
    logic                 r_calc_valid, w_calc_valid_n;
    logic                 r_err, w_err_n;
    logic                 w_accept;

    logic                 w_sel_b;
    logic [3:0]           w_acc_value;
    logic [c_cnt_w-1:0]   w_acc_count;
    logic [3:0]           w_acc_next_value;
    logic [c_cnt_w-1:0]   w_acc_next_count;
    logic                 w_acc_overflow;

`ifdef KEY_HOLDOFF_EN
    localparam int c_ho_w = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [c_ho_w-1:0] c_ho_load = c_ho_w'(HOLDOFF_CYCLES - 1);

    logic [c_ho_w-1:0] r_holdoff;

    assign w_accept = key_valid && (r_holdoff == '0);

    // A clear restarts entry immediately, so it leaves the mask open.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_holdoff <= '0;
        end else if (w_accept) begin
            r_holdoff <= (key_value == KEY_CLR) ? '0 : c_ho_load;
        end else if (r_holdoff != '0) begin
            r_holdoff <= r_holdoff - c_ho_w'(1);
        end
    end
`else
    assign w_accept = key_valid;
`endif

    // One accumulator serves both operands; only the active entry state uses it.
    assign w_sel_b     = (r_state == S_B);
    assign w_acc_value = w_sel_b ? r_b : r_a;
    assign w_acc_count = w_sel_b ? r_count_b : r_count_a;

    digit_accumulator #(
        .MAX_DIGITS (MAX_DIGITS),
        .CNT_W      (c_cnt_w)
    ) u_digit_accumulator (
        .cur_value  (w_acc_value),
        .cur_count  (w_acc_count),
        .digit      (key_value),
        .next_value (w_acc_next_value),
        .next_count (w_acc_next_count),
        .overflow   (w_acc_overflow)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_A;
            r_a          <= '0;
            r_b          <= '0;
            r_count_a    <= '0;
            r_count_b    <= '0;
            r_op         <= OP_ADD;
            r_calc_valid <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_a          <= w_a_n;
            r_b          <= w_b_n;
            r_count_a    <= w_count_a_n;
            r_count_b    <= w_count_b_n;
            r_op         <= w_op_n;
            r_calc_valid <= w_calc_valid_n;
            r_err        <= w_err_n;
        end
    end

    always_comb begin
        w_state_n      = r_state;
        w_a_n          = r_a;
        w_b_n          = r_b;
        w_count_a_n    = r_count_a;
        w_count_b_n    = r_count_b;
        w_op_n         = r_op;
        w_calc_valid_n = r_calc_valid;
        w_err_n        = r_err;

        if (w_accept) begin
            if (key_value == KEY_CLR) begin
                w_state_n      = S_A;
                w_a_n          = '0;
                w_b_n          = '0;
                w_count_a_n    = '0;
                w_count_b_n    = '0;
                w_op_n         = OP_ADD;
                w_calc_valid_n = 1'b0;
                w_err_n        = 1'b0;
            end else begin
                case (r_state)
                    S_A: begin
                        if (is_digit(key_value)) begin
                            if (w_acc_overflow) begin
                                w_state_n = S_ERR;
                                w_err_n   = 1'b1;
                            end else begin
                                w_a_n       = w_acc_next_value;
                                w_count_a_n = w_acc_next_count;
                            end
                        end else if (is_operator(key_value)) begin
                            w_op_n    = key_to_op(key_value);
                            w_state_n = S_B;
                        end
                    end
                    S_B: begin
                        if (is_digit(key_value)) begin
                            if (w_acc_overflow) begin
                                w_state_n = S_ERR;
                                w_err_n   = 1'b1;
                            end else begin
                                w_b_n       = w_acc_next_value;
                                w_count_b_n = w_acc_next_count;
                            end
                        end else if (is_operator(key_value)) begin
                            w_op_n = key_to_op(key_value);
                        end else if (key_value == KEY_EQ && r_count_b != '0) begin
                            if (r_op == OP_DIV && r_b == 4'd0) begin
                                w_state_n = S_ERR;
                                w_err_n   = 1'b1;
                            end else begin
                                w_state_n      = S_DONE;
                                w_calc_valid_n = 1'b1;
                            end
                        end
                    end
                    S_DONE: begin
                        // A digit after a result starts a fresh calculation with it.
                        if (is_digit(key_value)) begin
                            w_state_n      = S_A;
                            w_a_n          = key_value;
                            w_count_a_n    = c_cnt_w'(1);
                            w_b_n          = '0;
                            w_count_b_n    = '0;
                            w_op_n         = OP_ADD;
                            w_calc_valid_n = 1'b0;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign sw_word     = {r_a, r_b};
    assign op_sel      = r_op;
    assign calc_valid  = r_calc_valid;
    assign err         = r_err;
    assign entry_state = r_state;

endmodule

`default_nettype wire

// File: tb/tb_operand_entry_fsm.sv
//------------------------------------------------------------------------------
// Module   : tb_operand_entry_fsm
// Brief    : Directed self-checking bench for operand_entry_fsm.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_operand_entry_fsm;

`ifdef KEY_HOLDOFF_EN
    localparam int c_holdoff = 4;
    localparam int c_gap     = 3;
`else
    localparam int c_holdoff = 16;
    localparam int c_gap     = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_value = 4'd0;
    logic [7:0] sw_word;
    logic [2:0] op_sel;
    logic       calc_valid;
    logic       err;
    logic [1:0] entry_state;

    int errors = 0;
    int checks = 0;

    operand_entry_fsm #(
        .MAX_DIGITS     (2),
        .HOLDOFF_CYCLES (c_holdoff)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .key_valid   (key_valid),
        .key_value   (key_value),
        .sw_word     (sw_word),
        .op_sel      (op_sel),
        .calc_valid  (calc_valid),
        .err         (err),
        .entry_state (entry_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] e_sw, input logic [2:0] e_op,
                             input logic e_cv, input logic e_err, input logic [1:0] e_st);
        chk({tag, ".sw_word"}, sw_word, e_sw);
        chk({tag, ".op_sel"}, {5'd0, op_sel}, {5'd0, e_op});
        chk({tag, ".calc_valid"}, {7'd0, calc_valid}, {7'd0, e_cv});
        chk({tag, ".err"}, {7'd0, err}, {7'd0, e_err});
        chk({tag, ".state"}, {6'd0, entry_state}, {6'd0, e_st});
    endtask

    // Inputs change on the falling edge; outputs are read on a falling edge too.
    task automatic press(input logic [3:0] k);
        @(negedge clk);
        key_valid = 1'b1;
        key_value = k;
        @(negedge clk);
        key_valid = 1'b0;
        repeat (c_gap) @(negedge clk);
    endtask

    task automatic seq(input logic [3:0] keys[$]);
        foreach (keys[i]) press(keys[i]);
    endtask

    initial begin
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_all("reset", 8'h00, 3'b000, 1'b0, 1'b0, 2'b00);

        seq('{4'h1, 4'h2, 4'hA, 4'h3, 4'hF});
        check_all("add12_3", 8'hC3, 3'b000, 1'b1, 1'b0, 2'b10);

        seq('{4'h1, 4'h6});
        check_all("range_err", 8'h10, 3'b000, 1'b0, 1'b1, 2'b11);
        press(4'h5);
        check_all("err_ignores_digit", 8'h10, 3'b000, 1'b0, 1'b1, 2'b11);
        press(4'hE);
        check_all("clear", 8'h00, 3'b000, 1'b0, 1'b0, 2'b00);

        seq('{4'h9, 4'hD, 4'h0, 4'hF});
        check_all("div_by_zero", 8'h90, 3'b010, 1'b0, 1'b1, 2'b11);
        seq('{4'hE, 4'h8, 4'hD, 4'h2, 4'hF});
        check_all("div8_2", 8'h82, 3'b010, 1'b1, 1'b0, 2'b10);

        seq('{4'h7, 4'hB, 4'hC, 4'h4, 4'hF});
        check_all("last_op_wins", 8'h74, 3'b011, 1'b1, 1'b0, 2'b10);
        seq('{4'hA, 4'hF});
        check_all("done_ignores_op_eq", 8'h74, 3'b011, 1'b1, 1'b0, 2'b10);
        press(4'h5);
        check_all("restart_digit", 8'h50, 3'b000, 1'b0, 1'b0, 2'b00);

        seq('{4'hE, 4'h3, 4'hA, 4'hF});
        check_all("eq_no_b_ignored", 8'h30, 3'b000, 1'b0, 1'b0, 2'b01);
        @(negedge clk);
        reset     = 1'b1;
        key_valid = 1'b1;
        key_value = 4'h5;
        @(negedge clk);
        reset     = 1'b0;
        key_valid = 1'b0;
        check_all("reset_beats_key", 8'h00, 3'b000, 1'b0, 1'b0, 2'b00);

        seq('{4'h1, 4'h5});
        check_all("max_value_15", 8'hF0, 3'b000, 1'b0, 1'b0, 2'b00);
        seq('{4'hE, 4'h0, 4'h1, 4'h5});
        check_all("digit_count_err", 8'h10, 3'b000, 1'b0, 1'b1, 2'b11);

        seq('{4'hE, 4'hA, 4'h9, 4'h9, 4'hF});
        check_all("b_range_err", 8'h09, 3'b000, 1'b0, 1'b1, 2'b11);
        seq('{4'hE, 4'hA, 4'h9, 4'hF});
        check_all("empty_a", 8'h09, 3'b000, 1'b1, 1'b0, 2'b10);
        seq('{4'hE, 4'h6, 4'hB, 4'h1, 4'h5, 4'hF});
        check_all("sub6_15", 8'h6F, 3'b001, 1'b1, 1'b0, 2'b10);

`ifdef KEY_HOLDOFF_EN
        press(4'hE);
        @(negedge clk);
        key_valid = 1'b1;
        key_value = 4'h1;
        @(negedge clk);
        key_valid = 1'b0;
        @(negedge clk);
        key_valid = 1'b1;
        key_value = 4'h2;
        @(negedge clk);
        key_valid = 1'b0;
        chk("holdoff_masked", sw_word, 8'h10);
        @(negedge clk);
        key_valid = 1'b1;
        key_value = 4'h2;
        @(negedge clk);
        key_valid = 1'b0;
        chk("holdoff_expired", sw_word, 8'hC0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
